csa_resolve_seq: RTL and testbench



---
 rtl/csa_resolve_seq.sv | 117 +++++++++++
 tb/tb_csa_resolve_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_seq.sv
// Sequential carry-save to binary resolver: the pair is added CHUNK bits per
// clock, with valid/ready handshakes on the input and output sides.
module csa_resolve_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             t_q, t_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;

    // The only adder in the block: one CHUNK-wide slice plus the rippled carry.
    always_comb begin
        a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cin_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        t_d      = t_q;
        idx_d    = idx_q;
        cin_d    = cin_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_sum;
                    b_d     = in_carry << 1;
                    // The carry MSB shifts out of B; it can only add to overflow.
                    t_d     = in_carry[WIDTH-1];
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                result_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                cin_d = chunk_sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    ovf_d   = chunk_sum[CHUNK] | t_q;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= 1'b0;
            idx_q    <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            t_q      <= t_d;
            idx_q    <= idx_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Self-checking bench for csa_resolve_seq: directed corner cases plus random
// operand pairs compared against a plain-arithmetic reference model.
module tb_csa_resolve_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic [15:0] in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    csa_resolve_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_carry (in_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the carry word has weight two, so the true sum needs 18 bits.
    function automatic logic [17:0] model_full(input logic [15:0] s, input logic [15:0] c);
        int full;
        full = int'(s) + 2 * int'(c);
        return 18'(full);
    endfunction

    // Drives one transaction from IDLE and waits (bounded) for the result.
    task automatic do_op(input logic [15:0] s, input logic [15:0] c,
                         output int lat, output logic [15:0] r, output logic o, output bit to);
        @(negedge clk);
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        to  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i;
                to  = 1'b0;
                break;
            end
        end
        r = result;
        o = ovf;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (result !== 16'h0000) begin bad++; $display("[TB] FAIL reset_result got=%h exp=0000", result); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_directed(input string name, input logic [15:0] s, input logic [15:0] c,
                                 input logic [15:0] exp_r, input logic exp_o);
        int lat; logic [15:0] r; logic o; bit to;
        logic [17:0] full;
        full = model_full(s, c);
        do_op(s, c, lat, r, o, to);
        total++; if (to) begin bad++; $display("[TB] FAIL %s_timeout got=no out_valid exp=out_valid", name); end
        total++; if (lat !== 4) begin bad++; $display("[TB] FAIL %s_latency got=%0d exp=4", name, lat); end
        total++; if (r !== exp_r || r !== full[15:0]) begin bad++; $display("[TB] FAIL %s_result got=%h exp=%h", name, r, exp_r); end
        total++; if (o !== exp_o) begin bad++; $display("[TB] FAIL %s_ovf got=%b exp=%b", name, o, exp_o); end
    endtask

    task automatic test_random();
        int lat; logic [15:0] r; logic o; bit to;
        logic [15:0] s, c;
        logic [17:0] full;
        for (int n = 0; n < 25; n++) begin
            s = 16'($urandom);
            c = 16'($urandom);
            if (n % 5 == 0) c = 16'($urandom_range(0, 3)) << 14;
            full = model_full(s, c);
            do_op(s, c, lat, r, o, to);
            total++;
            if (to || lat !== 4 || r !== full[15:0] || o !== (full[17] | full[16])) begin
                bad++;
                $display("[TB] FAIL random_%0d got=%h/%b lat=%0d exp=%h/%b lat=4 (s=%h c=%h)",
                         n, r, o, lat, full[15:0], full[17] | full[16], s, c);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s1, c1, s2, c2, held;
        logic [17:0] f1, f2;
        bit seen;
        int busy_bad;
        s1 = 16'h3C5A; c1 = 16'h0F0F;
        s2 = 16'hBEEF; c2 = 16'h1234;
        f1 = model_full(s1, c1);
        f2 = model_full(s2, c2);
        busy_bad = 0;
        @(negedge clk);
        in_sum = s1; in_carry = c1; in_valid = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
            if (in_ready !== 1'b0) busy_bad++;
            in_sum = 16'($urandom); in_carry = 16'($urandom);
            if (!seen) @(posedge clk);
        end
        total++; if (!seen) begin bad++; $display("[TB] FAIL bp_timeout got=no out_valid exp=out_valid"); end
        held = result;
        total++; if (held !== f1[15:0] || ovf !== (f1[17] | f1[16])) begin bad++; $display("[TB] FAIL bp_result got=%h/%b exp=%h/%b", held, ovf, f1[15:0], f1[17] | f1[16]); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== f1[15:0] || in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_hold_%0d got=ov%b r=%h ir%b exp=ov1 r=%h ir0", i, out_valid, result, in_ready, f1[15:0]);
            end
            in_sum = 16'($urandom); in_carry = 16'($urandom);
        end
        total++; if (busy_bad != 0) begin bad++; $display("[TB] FAIL bp_busy_in_ready got=%0d high cycles exp=0", busy_bad); end
        in_sum = s2; in_carry = c2; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_consumed got=ir%b ov%b exp=ir1 ov0", in_ready, out_valid); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_accept got=ir%b exp=ir0", in_ready); end
        in_sum = 16'hFFFF; in_carry = 16'hFFFF;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || result !== f2[15:0] || ovf !== (f2[17] | f2[16])) begin
            bad++;
            $display("[TB] FAIL bp_second got=%h/%b seen=%b exp=%h/%b", result, ovf, seen, f2[15:0], f2[17] | f2[16]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_add();
        int rises;
        @(negedge clk);
        in_sum = 16'hAAAA; in_carry = 16'h5555; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midadd_in_ready got=%b exp=1", in_ready); end
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) rises++;
        end
        out_ready = 1'b0;
        total++; if (rises != 0) begin bad++; $display("[TB] FAIL midadd_no_output got=%0d valid cycles exp=0", rises); end
        test_directed("after_reset", 16'h1234, 16'h0010, 16'h1254, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed("basic", 16'h00FF, 16'h0001, 16'h0101, 1'b0);
        test_directed("full_ripple", 16'hFFFE, 16'h0001, 16'h0000, 1'b1);
        test_directed("top_bit", 16'hFFFF, 16'h8000, 16'hFFFF, 1'b1);
        test_random();
        test_backpressure();
        test_reset_mid_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
